bus_master_port: RTL and testbench

- Master-side initiator for the two-master system bus; it is the requesting end of the arbiter handshake.
- Accepts one command at a time from local logic (read or write, slave select, address, write data) and raises a request with a slave select.
- After grant, shifts address and write data out serially LSB-first, or shifts read data in.
- Pulses trans_done so the arbiter releases the bus, then returns a response to local logic.

---
 rtl/bus_pkg.sv | 28 ++
 rtl/bus_serial_shifter.sv | 50 +++++
 rtl/bus_master_port.sv | 264 ++++++++++++++++++++++++++
 tb/tb_bus_master_port.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master system bus: master-port FSM state
// encoding, slave select codes, master id codes and a small sizing helper.
package bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WDATA = 3'd3,
        ST_WAIT  = 3'd4,
        ST_RDATA = 3'd5,
        ST_DONE  = 3'd6
    } bus_state_e;

    localparam logic [1:0] SLAVE_0 = 2'd0;
    localparam logic [1:0] SLAVE_1 = 2'd1;
    localparam logic [1:0] SLAVE_2 = 2'd2;
    localparam logic [1:0] SLAVE_3 = 2'd3;

    // Values the arbiter places on bus_grant for each master.
    localparam logic [1:0] MASTER_ID_0 = 2'd1;
    localparam logic [1:0] MASTER_ID_1 = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bus_serial_shifter.sv
// Loadable shift register shared by the address, write-data and read-data
// phases. Shifts right: serial_out is bit 0, serial_in enters at the MSB, so
// after RD_WIDTH shifts the received word sits in the top RD_WIDTH bits.
// done is high during the cycle that moves the final bit of a len-bit phase;
// the bit counter wraps to 0 on that shift.
module bus_serial_shifter #(
    parameter int WIDTH     = 12,
    parameter int CNT_WIDTH = 4,
    parameter int RD_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_data,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic                 shift_en,
    input  logic                 serial_in,
    output logic                 serial_out,
    output logic                 done,
    output logic [RD_WIDTH-1:0]  rd_next
);

    logic [WIDTH-1:0]     sreg_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0]     shift_next_s;

    assign shift_next_s = {serial_in, sreg_r[WIDTH-1:1]};
    assign serial_out   = sreg_r[0];
    assign done         = (cnt_r == (len - CNT_WIDTH'(1)));
    assign rd_next      = shift_next_s[WIDTH-1 -: RD_WIDTH];

    // Shift register and bit counter: clear beats load beats shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_r <= '0;
            cnt_r  <= '0;
        end else if (clear) begin
            sreg_r <= '0;
            cnt_r  <= '0;
        end else if (load) begin
            sreg_r <= load_data;
            cnt_r  <= '0;
        end else if (shift_en) begin
            sreg_r <= shift_next_s;
            cnt_r  <= done ? '0 : (cnt_r + CNT_WIDTH'(1));
        end
    end

endmodule

// File: rtl/bus_master_port.sv
// Master-side initiator of the two-master system bus. Takes one local command,
// requests the bus, shifts address / write data out LSB-first or read data in,
// pulses trans_done to release the arbiter and reports a response.
// Losing grant mid-transfer restarts the transaction from address bit 0.
// Optional feature macro: BUS_TIMEOUT_EN (slave response timeout, rsp_err).
module bus_master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [1:0]            cmd_slave_sel,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  m_request,
    output logic [1:0]            m_slave_sel,
    input  logic                  m_grant,
    output logic                  m_rw,
    output logic                  m_addr_bit,
    output logic                  m_addr_valid,
    output logic                  m_wdata_bit,
    output logic                  m_wdata_valid,
    input  logic                  s_rdata_bit,
    input  logic                  s_rdata_valid,
    input  logic                  s_ready,
    output logic                  trans_done
);

    localparam int SH_W  = max_int(ADDR_WIDTH, DATA_WIDTH);
    localparam int CNT_W = $clog2(SH_W + 1);
    localparam logic [CNT_W-1:0] ADDR_LEN = CNT_W'(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] DATA_LEN = CNT_W'(DATA_WIDTH);

    bus_state_e            state_r;
    bus_state_e            state_next_s;

    logic                  write_r;
    logic [1:0]            sel_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] rdata_r;

    logic                  accept_s;
    logic                  capture_s;
    logic                  busy_s;
    logic                  timeout_s;

    logic                  sh_clear_s;
    logic                  sh_load_s;
    logic [SH_W-1:0]       sh_load_data_s;
    logic [CNT_W-1:0]      sh_len_s;
    logic                  sh_shift_s;
    logic                  sh_out_s;
    logic                  sh_done_s;
    logic [DATA_WIDTH-1:0] sh_rd_next_s;

    bus_serial_shifter #(
        .WIDTH     (SH_W),
        .CNT_WIDTH (CNT_W),
        .RD_WIDTH  (DATA_WIDTH)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .clear      (sh_clear_s),
        .load       (sh_load_s),
        .load_data  (sh_load_data_s),
        .len        (sh_len_s),
        .shift_en   (sh_shift_s),
        .serial_in  (s_rdata_bit),
        .serial_out (sh_out_s),
        .done       (sh_done_s),
        .rd_next    (sh_rd_next_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and shifter control; grant loss always falls back to REQ.
    always_comb begin
        state_next_s   = state_r;
        accept_s       = 1'b0;
        capture_s      = 1'b0;
        sh_clear_s     = 1'b0;
        sh_load_s      = 1'b0;
        sh_load_data_s = '0;
        sh_len_s       = ADDR_LEN;
        sh_shift_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (m_grant) begin
                    sh_load_s      = 1'b1;
                    sh_load_data_s = SH_W'(addr_r);
                    state_next_s   = ST_ADDR;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_ADDR: begin
                if (!m_grant) begin
                    sh_clear_s   = 1'b1;
                    state_next_s = ST_REQ;
                end else begin
                    sh_shift_s = 1'b1;
                    if (sh_done_s && write_r) begin
                        sh_load_s      = 1'b1;
                        sh_load_data_s = SH_W'(wdata_r);
                        state_next_s   = ST_WDATA;
                    end else if (sh_done_s) begin
                        sh_clear_s   = 1'b1;
                        state_next_s = ST_WAIT;
                    end else begin
                        state_next_s = ST_ADDR;
                    end
                end
            end
            ST_WDATA: begin
                sh_len_s = DATA_LEN;
                if (!m_grant) begin
                    sh_clear_s   = 1'b1;
                    state_next_s = ST_REQ;
                end else begin
                    sh_shift_s = 1'b1;
                    if (sh_done_s) begin
                        sh_clear_s   = 1'b1;
                        state_next_s = ST_WAIT;
                    end else begin
                        state_next_s = ST_WDATA;
                    end
                end
            end
            ST_WAIT, ST_RDATA: begin
                sh_len_s = DATA_LEN;
                if (!m_grant) begin
                    sh_clear_s   = 1'b1;
                    state_next_s = ST_REQ;
                end else if (write_r) begin
                    if (s_ready || timeout_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = state_r;
                    end
                end else if (s_rdata_valid) begin
                    sh_shift_s = 1'b1;
                    if (sh_done_s) begin
                        capture_s    = 1'b1;
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RDATA;
                    end
                end else if (timeout_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_DONE: begin
                sh_clear_s   = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: begin
                sh_clear_s   = 1'b1;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Command latch: captured only on accept, so cmd_valid while busy is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_r <= 1'b0;
            sel_r   <= 2'd0;
            addr_r  <= '0;
            wdata_r <= '0;
        end else if (accept_s) begin
            write_r <= cmd_write;
            sel_r   <= cmd_slave_sel;
            addr_r  <= cmd_addr;
            wdata_r <= cmd_wdata;
        end
    end

    // Read response register: updated only when the last read bit arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r <= '0;
        end else if (capture_s) begin
            rdata_r <= sh_rd_next_s;
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt_r;
    logic              err_r;
    logic              waiting_s;

    assign waiting_s = ((state_r == ST_WAIT) || (state_r == ST_RDATA)) && m_grant;
    assign timeout_s = (wait_cnt_r == WAIT_W'(TIMEOUT_CYCLES - 1)) && !s_ready && !s_rdata_valid;

    // Slave wait counter: counts idle cycles, restarts on any slave activity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= '0;
        end else if (waiting_s && !s_ready && !s_rdata_valid) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= '0;
        end
    end

    // Error flag: records whether DONE was reached by timeout; held through DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (state_r != ST_DONE) begin
            err_r <= waiting_s && timeout_s;
        end
    end

    assign rsp_err = (state_r == ST_DONE) && err_r;
`else
    assign timeout_s = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    assign busy_s        = (state_r == ST_ADDR) || (state_r == ST_WDATA) ||
                           (state_r == ST_WAIT) || (state_r == ST_RDATA);
    assign cmd_ready     = (state_r == ST_IDLE);
    assign m_request     = (state_r == ST_REQ) || busy_s;
    assign m_slave_sel   = (state_r != ST_IDLE) ? sel_r : 2'd0;
    assign m_rw          = busy_s && m_grant && write_r;
    assign m_addr_valid  = (state_r == ST_ADDR) && m_grant;
    assign m_addr_bit    = m_addr_valid && sh_out_s;
    assign m_wdata_valid = (state_r == ST_WDATA) && m_grant;
    assign m_wdata_bit   = m_wdata_valid && sh_out_s;
    assign trans_done    = (state_r == ST_DONE);
    assign rsp_valid     = (state_r == ST_DONE);
    assign rsp_rdata     = rdata_r;

endmodule

// File: tb/tb_bus_master_port.sv
// Directed self-checking bench for bus_master_port (default 12/8 geometry).
// Inputs change 1 time unit after the rising edge; outputs sampled at the
// falling edge. The timeout scenario is compiled only with BUS_TIMEOUT_EN.
module tb_bus_master_port;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_slave_sel = 2'd0;
    logic [11:0] cmd_addr = 12'h000;
    logic [7:0]  cmd_wdata = 8'h00;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        m_request;
    logic [1:0]  m_slave_sel;
    logic        m_grant = 1'b0;
    logic        m_rw;
    logic        m_addr_bit;
    logic        m_addr_valid;
    logic        m_wdata_bit;
    logic        m_wdata_valid;
    logic        s_rdata_bit = 1'b0;
    logic        s_rdata_valid = 1'b0;
    logic        s_ready = 1'b0;
    logic        trans_done;

    int compared   = 0;
    int mismatched = 0;
    int done_cnt   = 0;
    int rsp_cnt    = 0;

    bus_master_port dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_slave_sel (cmd_slave_sel),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .m_request     (m_request),
        .m_slave_sel   (m_slave_sel),
        .m_grant       (m_grant),
        .m_rw          (m_rw),
        .m_addr_bit    (m_addr_bit),
        .m_addr_valid  (m_addr_valid),
        .m_wdata_bit   (m_wdata_bit),
        .m_wdata_valid (m_wdata_valid),
        .s_rdata_bit   (s_rdata_bit),
        .s_rdata_valid (s_rdata_valid),
        .s_ready       (s_ready),
        .trans_done    (trans_done)
    );

    always #5 clk = ~clk;

    // Pulse counters for trans_done and rsp_valid.
    always @(negedge clk) begin
        if (trans_done === 1'b1) done_cnt++;
        if (rsp_valid === 1'b1) rsp_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] idle_outs();
        return {cmd_ready, m_request, m_slave_sel, m_rw, m_addr_bit, m_addr_valid,
                m_wdata_bit, m_wdata_valid, trans_done, rsp_valid, rsp_err};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        compared++; if (idle_outs() !== 12'b1000_0000_0000) begin mismatched++; $display("FAIL reset_outs: got %b want %b", idle_outs(), 12'b1000_0000_0000); end
        compared++; if (rsp_rdata !== 8'h00) begin mismatched++; $display("FAIL reset_rdata: got %h want %h", rsp_rdata, 8'h00); end
        cyc();
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_write();
        logic [11:0] a;
        logic [7:0]  d;
        int d0;
        a = 12'hA5C; d = 8'h3E; d0 = done_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_slave_sel = 2'd2; cmd_addr = a; cmd_wdata = d;
        @(negedge clk);
        compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL wr_cmd_ready: got %b want 1", cmd_ready); end
        cyc(); cmd_valid = 1'b0; m_grant = 1'b0;
        @(negedge clk);
        compared++; if ({m_request, m_slave_sel, cmd_ready} !== 4'b1100) begin mismatched++; $display("FAIL wr_req: got %b want %b", {m_request, m_slave_sel, cmd_ready}, 4'b1100); end
        cyc();
        cyc(); m_grant = 1'b1;
        @(negedge clk);
        compared++; if (m_addr_valid !== 1'b0) begin mismatched++; $display("FAIL wr_valid_before_grant: got %b want 0", m_addr_valid); end
        for (int i = 0; i < 12; i++) begin
            cyc(); @(negedge clk);
            compared++; if ({m_addr_valid, m_addr_bit, m_wdata_valid, m_rw} !== {1'b1, a[i], 1'b0, 1'b1}) begin mismatched++; $display("FAIL wr_addr[%0d]: got %b want %b", i, {m_addr_valid, m_addr_bit, m_wdata_valid, m_rw}, {1'b1, a[i], 1'b0, 1'b1}); end
        end
        for (int i = 0; i < 8; i++) begin
            cyc(); @(negedge clk);
            compared++; if ({m_wdata_valid, m_wdata_bit, m_addr_valid} !== {1'b1, d[i], 1'b0}) begin mismatched++; $display("FAIL wr_data[%0d]: got %b want %b", i, {m_wdata_valid, m_wdata_bit, m_addr_valid}, {1'b1, d[i], 1'b0}); end
        end
        cyc(); @(negedge clk);
        compared++; if ({m_wdata_valid, trans_done, m_request} !== 3'b001) begin mismatched++; $display("FAIL wr_wait: got %b want 001", {m_wdata_valid, trans_done, m_request}); end
        cyc();
        cyc(); s_ready = 1'b1;
        @(negedge clk);
        compared++; if (trans_done !== 1'b0) begin mismatched++; $display("FAIL wr_early_done: got %b want 0", trans_done); end
        cyc(); s_ready = 1'b0;
        @(negedge clk);
        compared++; if ({trans_done, rsp_valid, rsp_err, m_request} !== 4'b1100) begin mismatched++; $display("FAIL wr_done: got %b want 1100", {trans_done, rsp_valid, rsp_err, m_request}); end
        cyc(); @(negedge clk);
        compared++; if ({cmd_ready, trans_done} !== 2'b10) begin mismatched++; $display("FAIL wr_idle: got %b want 10", {cmd_ready, trans_done}); end
        compared++; if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL wr_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_read();
        logic [11:0] a;
        logic [7:0]  rd;
        int r0;
        int idx;
        a = 12'h001; rd = 8'hC3; r0 = rsp_cnt; idx = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_slave_sel = 2'd1; cmd_addr = a; cmd_wdata = 8'hFF;
        cyc(); cmd_valid = 1'b0; m_grant = 1'b1;
        @(negedge clk);
        compared++; if ({m_request, m_slave_sel} !== 3'b101) begin mismatched++; $display("FAIL rd_req: got %b want 101", {m_request, m_slave_sel}); end
        for (int i = 0; i < 12; i++) begin
            cyc(); @(negedge clk);
            compared++; if ({m_addr_valid, m_addr_bit, m_rw} !== {1'b1, a[i], 1'b0}) begin mismatched++; $display("FAIL rd_addr[%0d]: got %b want %b", i, {m_addr_valid, m_addr_bit, m_rw}, {1'b1, a[i], 1'b0}); end
        end
        cyc(); s_rdata_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (k == 4 || k == 5) begin
                s_rdata_valid = 1'b0;
            end else begin
                s_rdata_valid = 1'b1; s_rdata_bit = rd[idx]; idx++;
            end
            @(negedge clk);
            compared++; if ({rsp_valid, m_request} !== 2'b01) begin mismatched++; $display("FAIL rd_busy[%0d]: got %b want 01", k, {rsp_valid, m_request}); end
        end
        cyc(); s_rdata_valid = 1'b0; s_rdata_bit = 1'b0;
        @(negedge clk);
        compared++; if ({rsp_valid, trans_done, rsp_err} !== 3'b110) begin mismatched++; $display("FAIL rd_done: got %b want 110", {rsp_valid, trans_done, rsp_err}); end
        compared++; if (rsp_rdata !== 8'hC3) begin mismatched++; $display("FAIL rd_data: got %h want %h", rsp_rdata, 8'hC3); end
        cyc(); @(negedge clk);
        compared++; if ({rsp_valid, rsp_rdata} !== {1'b0, 8'hC3}) begin mismatched++; $display("FAIL rd_hold: got %b/%h want 0/c3", rsp_valid, rsp_rdata); end
        compared++; if (rsp_cnt - r0 !== 1) begin mismatched++; $display("FAIL rd_rsp_count: got %0d want 1", rsp_cnt - r0); end
    endtask

    task automatic test_preempt();
        logic [11:0] a;
        logic [7:0]  d;
        int d0;
        int r0;
        a = 12'h123; d = 8'h5A; d0 = done_cnt; r0 = rsp_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_slave_sel = 2'd3; cmd_addr = a; cmd_wdata = d;
        cyc(); cmd_valid = 1'b0; m_grant = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(); @(negedge clk);
            compared++; if ({m_addr_valid, m_addr_bit} !== {1'b1, a[i]}) begin mismatched++; $display("FAIL pe_addr1[%0d]: got %b want %b", i, {m_addr_valid, m_addr_bit}, {1'b1, a[i]}); end
        end
        cyc(); m_grant = 1'b0;
        @(negedge clk);
        compared++; if ({m_addr_valid, m_wdata_valid, m_rw, m_request} !== 4'b0001) begin mismatched++; $display("FAIL pe_drop: got %b want 0001", {m_addr_valid, m_wdata_valid, m_rw, m_request}); end
        cyc(); m_grant = 1'b1;
        @(negedge clk);
        compared++; if ({m_request, m_addr_valid, m_slave_sel} !== 4'b1011) begin mismatched++; $display("FAIL pe_req: got %b want 1011", {m_request, m_addr_valid, m_slave_sel}); end
        for (int i = 0; i < 12; i++) begin
            cyc(); @(negedge clk);
            compared++; if ({m_addr_valid, m_addr_bit} !== {1'b1, a[i]}) begin mismatched++; $display("FAIL pe_addr2[%0d]: got %b want %b", i, {m_addr_valid, m_addr_bit}, {1'b1, a[i]}); end
        end
        for (int i = 0; i < 8; i++) begin
            cyc(); @(negedge clk);
            compared++; if ({m_wdata_valid, m_wdata_bit} !== {1'b1, d[i]}) begin mismatched++; $display("FAIL pe_data[%0d]: got %b want %b", i, {m_wdata_valid, m_wdata_bit}, {1'b1, d[i]}); end
        end
        cyc(); s_ready = 1'b1;
        cyc(); s_ready = 1'b0;
        @(negedge clk);
        compared++; if (trans_done !== 1'b1) begin mismatched++; $display("FAIL pe_done: got %b want 1", trans_done); end
        cyc(); @(negedge clk);
        compared++; if ({done_cnt - d0, rsp_cnt - r0} !== {32'd1, 32'd1}) begin mismatched++; $display("FAIL pe_counts: got %0d/%0d want 1/1", done_cnt - d0, rsp_cnt - r0); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] a;
        logic [7:0]  d;
        logic [11:0] b;
        bit found;
        a = 12'h0F0; d = 8'h11; b = 12'h00F; found = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_slave_sel = 2'd0; cmd_addr = a; cmd_wdata = d;
        m_grant = 1'b1;
        cyc();
        cmd_slave_sel = 2'd3; cmd_addr = 12'hFFF; cmd_wdata = 8'hFF; cmd_write = 1'b0;
        @(negedge clk);
        compared++; if ({cmd_ready, m_slave_sel} !== 3'b000) begin mismatched++; $display("FAIL bb_busy: got %b want 000", {cmd_ready, m_slave_sel}); end
        for (int i = 0; i < 12; i++) begin
            cyc(); @(negedge clk);
            compared++; if ({m_addr_valid, m_addr_bit, m_rw} !== {1'b1, a[i], 1'b1}) begin mismatched++; $display("FAIL bb_addr_a[%0d]: got %b want %b", i, {m_addr_valid, m_addr_bit, m_rw}, {1'b1, a[i], 1'b1}); end
        end
        for (int i = 0; i < 8; i++) begin
            cyc(); @(negedge clk);
            compared++; if ({m_wdata_valid, m_wdata_bit} !== {1'b1, d[i]}) begin mismatched++; $display("FAIL bb_data_a[%0d]: got %b want %b", i, {m_wdata_valid, m_wdata_bit}, {1'b1, d[i]}); end
        end
        cyc(); s_ready = 1'b1;
        cmd_write = 1'b1; cmd_slave_sel = 2'd1; cmd_addr = b; cmd_wdata = 8'h22;
        cyc(); s_ready = 1'b0;
        @(negedge clk);
        compared++; if ({trans_done, cmd_ready} !== 2'b10) begin mismatched++; $display("FAIL bb_done_a: got %b want 10", {trans_done, cmd_ready}); end
        cyc(); @(negedge clk);
        compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL bb_idle: got %b want 1", cmd_ready); end
        cyc(); cmd_valid = 1'b0;
        @(negedge clk);
        compared++; if ({m_request, m_slave_sel} !== 3'b101) begin mismatched++; $display("FAIL bb_req_b: got %b want 101", {m_request, m_slave_sel}); end
        for (int i = 0; i < 12; i++) begin
            cyc(); @(negedge clk);
            compared++; if ({m_addr_valid, m_addr_bit} !== {1'b1, b[i]}) begin mismatched++; $display("FAIL bb_addr_b[%0d]: got %b want %b", i, {m_addr_valid, m_addr_bit}, {1'b1, b[i]}); end
        end
        s_ready = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc(); @(negedge clk);
            if (trans_done === 1'b1) found = 1'b1;
        end
        s_ready = 1'b0;
        compared++; if (found !== 1'b1) begin mismatched++; $display("FAIL bb_done_b: got %b want 1 (timeout)", found); end
        cyc();
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        int early;
        early = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_slave_sel = 2'd0; cmd_addr = 12'h000;
        m_grant = 1'b1; s_ready = 1'b0; s_rdata_valid = 1'b0;
        cyc(); cmd_valid = 1'b0;
        repeat (12) cyc();
        for (int k = 0; k < 64; k++) begin
            cyc(); @(negedge clk);
            if (trans_done !== 1'b0) early++;
        end
        compared++; if (early !== 0) begin mismatched++; $display("FAIL to_early: got %0d early pulses want 0", early); end
        cyc(); @(negedge clk);
        compared++; if ({trans_done, rsp_valid, rsp_err} !== 3'b111) begin mismatched++; $display("FAIL to_done: got %b want 111", {trans_done, rsp_valid, rsp_err}); end
        compared++; if (rsp_rdata !== 8'hC3) begin mismatched++; $display("FAIL to_rdata: got %h want %h", rsp_rdata, 8'hC3); end
        cyc(); @(negedge clk);
        compared++; if ({rsp_err, cmd_ready} !== 2'b01) begin mismatched++; $display("FAIL to_idle: got %b want 01", {rsp_err, cmd_ready}); end
    endtask
`endif

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_slave_sel = 2'd2; cmd_addr = 12'h3C3; cmd_wdata = 8'hAA;
        cyc(); cmd_valid = 1'b0; m_grant = 1'b1;
        repeat (15) cyc();
        @(negedge clk);
        compared++; if (m_wdata_valid !== 1'b1) begin mismatched++; $display("FAIL rm_in_wdata: got %b want 1", m_wdata_valid); end
        #1 rst = 1'b0;
        #1;
        compared++; if (idle_outs() !== 12'b1000_0000_0000) begin mismatched++; $display("FAIL rm_async: got %b want %b", idle_outs(), 12'b1000_0000_0000); end
        m_grant = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        cyc(); @(negedge clk);
        compared++; if ({cmd_ready, m_request, done_cnt - d0} !== {1'b1, 1'b0, 32'd0}) begin mismatched++; $display("FAIL rm_after: got %b%b/%0d want 10/0", cmd_ready, m_request, done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_preempt();
        test_back_to_back();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
